vec_load_sequencer: RTL and testbench
=====================================

Name: vec_load_sequencer

Overview:
- Upstream feeder for the vector register file write port.
- Gathers one vector from byte-lane memory, reading one element per memory handshake at base + lane*stride.
- Assembles the elements into a packed vector, then issues a single-cycle register-file write (regWrEn/regToWrite/regWriteData) and pulses done.
- Sits between the decode/issue logic and data memory in the vector load path.

Parameters:
- registerSize, 8, width in bits of one vector element (lane).
- vectorSize, 4, number of lanes per vector.
- addrWidth, 16, memory address width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  load request; sampled only in IDLE.
- baseAddr  input  addrWidth  address of lane 0.
- stride  input  addrWidth  unsigned address increment between lanes.
- destReg  input  3  destination vector register index.
- busy  output  1  high in any state other than IDLE.
- memReq  output  1  memory read request.
- memAddr  output  addrWidth  read address; valid while memReq=1.
- memAck  input  1  read complete; memRdData valid in the same cycle.
- memRdData  input  registerSize  read data.
- regWrEn  output  1  register-file write enable, one-cycle pulse.
- regToWrite  output  3  register-file write index.
- regWriteData  output  vectorSize*registerSize  packed vector, lane 0 in the LSBs.
- done  output  1  completion pulse, coincident with regWrEn.
- error  output  1  timeout abort pulse (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE, lane counter = 0, lane buffer = 0.
  - All outputs = 0: busy, memReq, memAddr, regWrEn, regToWrite, regWriteData, done, error.
  - A load in progress is discarded; no register write occurs.
- All outputs are registered, so regWrEn is glitch-free. This is required because the register file gates its clock with the write enable.
- States and transitions:
  - IDLE: start=1 latches destReg into regToWrite, latches stride, sets memAddr = baseAddr, lane = 0, memReq = 1, and moves to REQ. start=0 stays in IDLE.
  - REQ: memReq=1 and memAddr are held stable until memAck=1. On memAck:
    - buffer[lane] <= memRdData.
    - If lane < vectorSize-1: lane++, memAddr += stride, stay in REQ with memReq still 1.
    - If lane == vectorSize-1: memReq <= 0, regWrEn <= 1, done <= 1, go to WRITE.
  - WRITE: lasts exactly one cycle with regWrEn=1 and done=1, then returns to IDLE with regWrEn=0 and done=0.
- Address arithmetic is modulo 2^addrWidth; wrap-around is silent.
- memAck while memReq=0 is ignored.
- start while busy=1 is ignored; it is not queued.
- start may be accepted in the same edge that WRITE exits to IDLE only one cycle later. Minimum spacing between accepted starts is vectorSize+2 cycles.
- Latency with zero-wait memory (memAck=1 whenever memReq=1):
  - start sampled at edge 0.
  - Acks sampled at edges 1..vectorSize.
  - regWrEn high after edge vectorSize.
  - IDLE after edge vectorSize+1.
- regWriteData holds the last assembled vector after the write, and is updated only while in REQ.
- regToWrite holds its value until the next accepted start.

Optional Feature:
- Macro: VEC_LOAD_TIMEOUT_EN.
- With the macro defined:
  - A 4-bit wait counter clears on entry to REQ and on every memAck, and increments each REQ cycle without memAck.
  - When the counter reaches 15 with no memAck: memReq <= 0, error <= 1 for one cycle, state goes to IDLE, and no regWrEn is issued. The lane buffer is left unchanged.
- Without the macro: there is no counter, error is constant 0, and REQ waits indefinitely.

Test Plan:
- Reset: assert reset=0 mid-simulation -> all outputs 0 immediately (asynchronous), busy=0.
- Basic load: baseAddr=0x0010, stride=1, destReg=5, zero-wait memory returning 0x11,0x22,0x33,0x44 -> memAddr sequence 0x0010..0x0013, regWriteData=0x44332211, regToWrite=5, regWrEn and done high for exactly 1 cycle, 4 cycles after start.
- Wrap/stride: baseAddr=0xFFFC, stride=4 -> memAddr 0xFFFC, 0x0000, 0x0004, 0x0008.
- Wait states: memAck withheld 3 cycles on lane 2 -> memReq and memAddr=base+2*stride held stable; regWrEn delayed by exactly 3 cycles.
- Interference: start pulsed during lane 1 -> ignored, single write only. Reset asserted during lane 2 -> no regWrEn; after release, a new start yields a correct load.
- VEC_LOAD_TIMEOUT_EN: no memAck for 15 REQ cycles -> error=1 for one cycle, memReq=0, busy=0, regWrEn never asserted. Without the macro -> still waiting, error=0.

Source files
------------

// File: rtl/vec_load_sequencer.sv
// Vector load sequencer: gathers vectorSize strided elements from memory and issues one register-file write.
// Optional timeout abort is compiled in with VEC_LOAD_TIMEOUT_EN.
module vec_load_sequencer #(
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int addrWidth    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [addrWidth-1:0]                 baseAddr,
  input  logic [addrWidth-1:0]                 stride,
  input  logic [2:0]                           destReg,
  output logic                                 busy,
  output logic                                 memReq,
  output logic [addrWidth-1:0]                 memAddr,
  input  logic                                 memAck,
  input  logic [registerSize-1:0]              memRdData,
  output logic                                 regWrEn,
  output logic [2:0]                           regToWrite,
  output logic [vectorSize*registerSize-1:0]   regWriteData,
  output logic                                 done,
  output logic                                 error
);

  localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(vectorSize - 1);

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t               state;
  logic [LW-1:0]        lane;
  logic [addrWidth-1:0] stride_q;
`ifdef VEC_LOAD_TIMEOUT_EN
  logic [3:0]           wait_cnt;
`endif

  // Every output is a flop: the register file gates its clock with regWrEn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lane         <= '0;
      stride_q     <= '0;
      busy         <= 1'b0;
      memReq       <= 1'b0;
      memAddr      <= '0;
      regWrEn      <= 1'b0;
      regToWrite   <= '0;
      regWriteData <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef VEC_LOAD_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      regWrEn <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            busy       <= 1'b1;
            memReq     <= 1'b1;
            memAddr    <= baseAddr;
            stride_q   <= stride;
            regToWrite <= destReg;
            lane       <= '0;
`ifdef VEC_LOAD_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
        REQ: begin
          if (memAck) begin
            for (int i = 0; i < vectorSize; i++) begin
              if (lane == LW'(i)) regWriteData[i*registerSize +: registerSize] <= memRdData;
            end
`ifdef VEC_LOAD_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (lane == LAST_LANE) begin
              memReq  <= 1'b0;
              regWrEn <= 1'b1;
              done    <= 1'b1;
              state   <= WRITE;
            end else begin
              lane    <= lane + 1'b1;
              memAddr <= memAddr + stride_q;
            end
          end
`ifdef VEC_LOAD_TIMEOUT_EN
          // Fifteenth consecutive un-acked request cycle: abandon the load.
          else if (wait_cnt == 4'd14) begin
            memReq   <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          memReq <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Self-checking bench for vec_load_sequencer: directed loads with literal expectations plus
// randomized traffic compared every cycle against a lane/address-level reference model.
module tb_vec_load_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] baseAddr = '0;
  logic [15:0] stride = '0;
  logic [2:0]  destReg = '0;
  logic        busy, memReq, regWrEn, done, error;
  logic [15:0] memAddr;
  logic        memAck = 1'b0;
  logic [7:0]  memRdData = '0;
  logic [2:0]  regToWrite;
  logic [31:0] regWriteData;

  int checks = 0;
  int errors = 0;

  vec_load_sequencer #(.registerSize(8), .vectorSize(4), .addrWidth(16)) dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .stride(stride),
    .destReg(destReg), .busy(busy), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memRdData(memRdData), .regWrEn(regWrEn), .regToWrite(regToWrite),
    .regWriteData(regWriteData), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: a load is "fetching lane k" or "writing"; address = base + k*stride.
  bit          m_req, m_wr, m_err;
  int          m_lane, m_wait;
  logic [15:0] m_base, m_stride;
  logic [2:0]  m_dest;
  logic [7:0]  m_vec [4];

  function automatic logic [31:0] m_packed();
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = m_vec[i];
    return v;
  endfunction

  function automatic logic [15:0] m_addr();
    logic [31:0] t = 32'(m_base) + 32'(m_lane) * 32'(m_stride);
    return t[15:0];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_req = 0; m_wr = 0; m_err = 0; m_lane = 0; m_wait = 0;
      m_base = '0; m_stride = '0; m_dest = '0;
      for (int i = 0; i < 4; i++) m_vec[i] = '0;
    end else begin
      m_err = 0;
      if (m_wr) begin
        m_wr = 0;
      end else if (m_req) begin
        if (memAck) begin
          m_vec[m_lane] = memRdData;
          m_wait = 0;
          if (m_lane == 3) begin m_req = 0; m_wr = 1; end
          else m_lane++;
        end else begin
`ifdef VEC_LOAD_TIMEOUT_EN
          m_wait++;
          if (m_wait == 15) begin m_req = 0; m_err = 1; end
`endif
        end
      end else if (start) begin
        m_req = 1; m_lane = 0; m_wait = 0;
        m_base = baseAddr; m_stride = stride; m_dest = destReg;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("busy", 64'(busy), 64'(m_req || m_wr));
      chk("memReq", 64'(memReq), 64'(m_req));
      if (m_req) chk("memAddr", 64'(memAddr), 64'(m_addr()));
      chk("regWrEn", 64'(regWrEn), 64'(m_wr));
      chk("done", 64'(done), 64'(m_wr));
      chk("regToWrite", 64'(regToWrite), 64'(m_dest));
      chk("regWriteData", 64'(regWriteData), 64'(m_packed()));
      chk("error", 64'(error), 64'(m_err));
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'(0));
    chk({nm, "_memReq"}, 64'(memReq), 64'(0));
    chk({nm, "_memAddr"}, 64'(memAddr), 64'(0));
    chk({nm, "_regWrEn"}, 64'(regWrEn), 64'(0));
    chk({nm, "_regToWrite"}, 64'(regToWrite), 64'(0));
    chk({nm, "_regWriteData"}, 64'(regWriteData), 64'(0));
    chk({nm, "_done"}, 64'(done), 64'(0));
    chk({nm, "_error"}, 64'(error), 64'(0));
  endtask

  // One load with literal expectations; optional wait states on one lane and a stray start on lane 1.
  task automatic run_load(input logic [15:0] b, input logic [15:0] s, input logic [2:0] d,
                          input logic [31:0] dat, input int wlane, input int wn,
                          input logic [63:0] eaddr, input logic [31:0] evec, input bit mid_start);
    int cycles = 0;
    @(negedge clk);
    start = 1'b1; baseAddr = b; stride = s; destReg = d; memAck = 1'b0;
    for (int ln = 0; ln < 4; ln++) begin
      int waits = (ln == wlane) ? wn : 0;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        cycles++;
        start = (mid_start && ln == 1 && w == 0);
        chk("dir_memReq", 64'(memReq), 64'(1));
        chk("dir_memAddr", 64'(memAddr), 64'(eaddr[ln*16 +: 16]));
        memAck = (w == waits);
        memRdData = memAck ? dat[ln*8 +: 8] : 8'($urandom);
      end
    end
    @(negedge clk);
    cycles++;
    start = 1'b0; memAck = 1'($urandom);
    chk("dir_regWrEn", 64'(regWrEn), 64'(1));
    chk("dir_done", 64'(done), 64'(1));
    chk("dir_memReq_off", 64'(memReq), 64'(0));
    chk("dir_vector", 64'(regWriteData), 64'(evec));
    chk("dir_dest", 64'(regToWrite), 64'(d));
    chk("dir_latency", 64'(cycles), 64'(5 + wn));
    @(negedge clk);
    memAck = 1'b0;
    chk("dir_wren_pulse", 64'(regWrEn), 64'(0));
    chk("dir_done_pulse", 64'(done), 64'(0));
    chk("dir_idle", 64'(busy), 64'(0));
    chk("dir_vector_hold", 64'(regWriteData), 64'(evec));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    #1 reset = 1'b1;

    run_load(16'h0010, 16'h0001, 3'd5, 32'h44332211, -1, 0,
             {16'h0013, 16'h0012, 16'h0011, 16'h0010}, 32'h44332211, 1'b0);
    run_load(16'hFFFC, 16'h0004, 3'd2, 32'h0BADF00D, -1, 0,
             {16'h0008, 16'h0004, 16'h0000, 16'hFFFC}, 32'h0BADF00D, 1'b0);
    run_load(16'h0100, 16'h0010, 3'd3, 32'hDEADBEEF, 2, 3,
             {16'h0130, 16'h0120, 16'h0110, 16'h0100}, 32'hDEADBEEF, 1'b0);
    run_load(16'h2000, 16'h0002, 3'd7, 32'hA5A55A5A, -1, 0,
             {16'h2006, 16'h2004, 16'h2002, 16'h2000}, 32'hA5A55A5A, 1'b1);

    // Memory that never answers.
    @(negedge clk);
    start = 1'b1; baseAddr = 16'h0300; stride = 16'h0001; destReg = 3'd1; memAck = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
`ifdef VEC_LOAD_TIMEOUT_EN
      chk("to_memReq", 64'(memReq), 64'(c <= 15));
      chk("to_busy", 64'(busy), 64'(c <= 15));
      chk("to_error", 64'(error), 64'(c == 16));
`else
      chk("to_memReq", 64'(memReq), 64'(1));
      chk("to_busy", 64'(busy), 64'(1));
      chk("to_error", 64'(error), 64'(0));
`endif
      chk("to_regWrEn", 64'(regWrEn), 64'(0));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      memAck = (c < 4); memRdData = 8'($urandom);
    end
    @(negedge clk);
    memAck = 1'b0;

    // Reset in the middle of lane 2.
    @(negedge clk);
    start = 1'b1; baseAddr = 16'h0040; stride = 16'h0001; destReg = 3'd6;
    @(negedge clk); start = 1'b0; memAck = 1'b1; memRdData = 8'h01;
    @(negedge clk); memAck = 1'b1; memRdData = 8'h02;
    @(negedge clk); memAck = 1'b0;
    #2 reset = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    chk("midreset_nowrite", 64'(regWrEn), 64'(0));
    #2 reset = 1'b1;
    run_load(16'h0050, 16'h0003, 3'd4, 32'h87654321, 0, 2,
             {16'h0059, 16'h0056, 16'h0053, 16'h0050}, 32'h87654321, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 3) == 0);
      baseAddr  = 16'($urandom);
      stride    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      destReg   = 3'($urandom);
      memAck    = ($urandom_range(0, 2) != 0);
      memRdData = 8'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0; memAck = 1'b1; memRdData = 8'($urandom);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
